// File: rtl/regs_bus_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : regs_bus_arbiter
//  Purpose  : Two-requester round-robin arbiter/sequencer in front of the
//             32-bit register block (DATA0 / DATA0_SR / DATA1 / DATA1_SR).
//             Exactly one single-cycle wr_en/rd_en access is issued at a
//             time; the result returns as a one-cycle ack, with err set for
//             unmapped or unaligned addresses (those never reach the block).
//  Ports    : clk, rst_n              - clock, async active-low reset
//             mX_req/we/addr/wdata    - request from master X (0 or 1)
//             mX_ack/err/rdata        - registered response to master X
//             wr_en/rd_en/addr/wdata  - registered register-block strobes
//             rdata                   - register-block read data (comb.)
//  Revision : 1.0 - initial release
// ============================================================================
module regs_bus_arbiter #(
  parameter int               DW            = 32,
  parameter int               AW            = 10,
  parameter logic [AW-1:0]    ADDR_DATA0    = 10'h0,
  parameter logic [AW-1:0]    ADDR_DATA0_SR = 10'h4,
  parameter logic [AW-1:0]    ADDR_DATA1    = 10'h8,
  parameter logic [AW-1:0]    ADDR_DATA1_SR = 10'hC
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  output logic          m0_ack,
  output logic          m0_err,
  output logic [DW-1:0] m0_rdata,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  output logic          m1_ack,
  output logic          m1_err,
  output logic [DW-1:0] m1_rdata,
  output logic          wr_en,
  output logic          rd_en,
  output logic [AW-1:0] addr,
  output logic [DW-1:0] wdata,
  input  logic [DW-1:0] rdata
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_RESP   = 2'd2;

  logic [1:0]    r_state;
  logic          r_last_grant;
  logic          r_sel;
  logic          r_err_pend;
  logic          r_rd_pend;
  logic          r_wr_en;
  logic          r_rd_en;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_wdata;
  logic          r_m0_ack;
  logic          r_m0_err;
  logic [DW-1:0] r_m0_rdata;
  logic          r_m1_ack;
  logic          r_m1_err;
  logic [DW-1:0] r_m1_rdata;

  logic          w_gnt1;
  logic          w_any;
  logic          w_we;
  logic [AW-1:0] w_addr;
  logic [DW-1:0] w_wdata;
  logic          w_legal;

  // Master 1 wins when it is alone, or on a tie when master 0 was served
  // last (r_last_grant == 0). Otherwise the grant falls to master 0.
  assign w_gnt1  = m1_req & (~m0_req | ~r_last_grant);
  assign w_any   = m0_req | m1_req;
  assign w_we    = w_gnt1 ? m1_we    : m0_we;
  assign w_addr  = w_gnt1 ? m1_addr  : m0_addr;
  assign w_wdata = w_gnt1 ? m1_wdata : m0_wdata;

  // Exact match against the four word addresses also rejects unaligned ones.
  assign w_legal = (w_addr == ADDR_DATA0)    | (w_addr == ADDR_DATA0_SR) |
                   (w_addr == ADDR_DATA1)    | (w_addr == ADDR_DATA1_SR);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_last_grant <= 1'b1;
      r_sel        <= 1'b0;
      r_err_pend   <= 1'b0;
      r_rd_pend    <= 1'b0;
      r_wr_en      <= 1'b0;
      r_rd_en      <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_m0_ack     <= 1'b0;
      r_m0_err     <= 1'b0;
      r_m0_rdata   <= '0;
      r_m1_ack     <= 1'b0;
      r_m1_err     <= 1'b0;
      r_m1_rdata   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_sel        <= w_gnt1;
            r_last_grant <= w_gnt1;
            r_err_pend   <= ~w_legal;
            r_rd_pend    <= w_legal & ~w_we;
            // Illegal requests still pass through ACCESS so every
            // transaction has the same 3-cycle shape, just without strobes.
            if (w_legal) begin
              r_wr_en <= w_we;
              r_rd_en <= ~w_we;
              r_addr  <= w_addr;
              r_wdata <= w_wdata;
            end
            r_state <= S_ACCESS;
          end
        end
        S_ACCESS: begin
          r_wr_en <= 1'b0;
          r_rd_en <= 1'b0;
          r_addr  <= '0;
          r_wdata <= '0;
          if (r_sel) begin
            r_m1_ack   <= 1'b1;
            r_m1_err   <= r_err_pend;
            r_m1_rdata <= r_rd_pend ? rdata : '0;
          end else begin
            r_m0_ack   <= 1'b1;
            r_m0_err   <= r_err_pend;
            r_m0_rdata <= r_rd_pend ? rdata : '0;
          end
          r_state <= S_RESP;
        end
        S_RESP: begin
          // rdata registers hold until that port's next response.
          r_m0_ack <= 1'b0;
          r_m0_err <= 1'b0;
          r_m1_ack <= 1'b0;
          r_m1_err <= 1'b0;
          r_state  <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign wr_en    = r_wr_en;
  assign rd_en    = r_rd_en;
  assign addr     = r_addr;
  assign wdata    = r_wdata;
  assign m0_ack   = r_m0_ack;
  assign m0_err   = r_m0_err;
  assign m0_rdata = r_m0_rdata;
  assign m1_ack   = r_m1_ack;
  assign m1_err   = r_m1_err;
  assign m1_rdata = r_m1_rdata;

endmodule
`default_nettype wire

// File: tb/tb_regs_bus_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_regs_bus_arbiter
//  Purpose  : Self-checking bench for regs_bus_arbiter with a register-block
//             model, a transaction-level reference model and directed plus
//             randomized traffic from both masters.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_regs_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [9:0]  m0_addr, m1_addr;
  logic [31:0] m0_wdata, m1_wdata;
  logic        m0_ack, m0_err, m1_ack, m1_err;
  logic [31:0] m0_rdata, m1_rdata;
  logic        wr_en, rd_en;
  logic [9:0]  addr;
  logic [31:0] wdata, rdata;

  regs_bus_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_ack(m0_ack), .m0_err(m0_err), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_ack(m1_ack), .m1_err(m1_err), .m1_rdata(m1_rdata),
    .wr_en(wr_en), .rd_en(rd_en), .addr(addr), .wdata(wdata), .rdata(rdata)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int n_strobes = 0;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (wr_en || rd_en) n_strobes <= n_strobes + 1;

  // ---------------- register block (environment) ----------------
  logic [31:0] env_regs [4];
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      env_regs[0] <= 32'h0;          env_regs[1] <= 32'h0;
      env_regs[2] <= 32'hffff_ffff;  env_regs[3] <= 32'hffff_ffff;
    end else if (wr_en) begin
      env_regs[addr[3:2]] <= wdata;
    end
  end
  assign rdata = rd_en ? env_regs[addr[3:2]] : 32'h0;

  // ---------------- reference model ----------------
  function automatic bit legal(input logic [9:0] a);
    return (a == 10'h0) || (a == 10'h4) || (a == 10'h8) || (a == 10'hC);
  endfunction

  logic        m_last;        // port served most recently
  int          m_age;         // cycles since grant of the open transaction
  logic        t_sel, t_we, t_legal;
  logic [9:0]  t_addr;
  logic [31:0] t_wdata;
  logic [31:0] m_regs [4];
  logic        e_wr, e_rd;
  logic [9:0]  e_addr;
  logic [31:0] e_wdata;
  logic [1:0]  e_ack, e_err;
  logic [31:0] e_rdata [2];

  // Winner among current requests: the lone requester, or the other one
  // than last served on a tie.
  logic        g;
  logic        g_we;
  logic [9:0]  g_addr;
  logic [31:0] g_wdata;
  assign g       = (m0_req && m1_req) ? ~m_last : m1_req;
  assign g_we    = g ? m1_we    : m0_we;
  assign g_addr  = g ? m1_addr  : m0_addr;
  assign g_wdata = g ? m1_wdata : m0_wdata;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_last <= 1'b1; m_age <= 0;
      t_sel <= 1'b0; t_we <= 1'b0; t_legal <= 1'b0; t_addr <= '0; t_wdata <= '0;
      m_regs[0] <= 32'h0;         m_regs[1] <= 32'h0;
      m_regs[2] <= 32'hffff_ffff; m_regs[3] <= 32'hffff_ffff;
      e_wr <= 1'b0; e_rd <= 1'b0; e_addr <= '0; e_wdata <= '0;
      e_ack <= 2'b00; e_err <= 2'b00; e_rdata[0] <= '0; e_rdata[1] <= '0;
    end else begin
      e_wr <= 1'b0; e_rd <= 1'b0; e_addr <= '0; e_wdata <= '0;
      e_ack <= 2'b00; e_err <= 2'b00;
      if (m_age == 1) begin
        e_ack[t_sel]   <= 1'b1;
        e_err[t_sel]   <= ~t_legal;
        e_rdata[t_sel] <= (t_legal && !t_we) ? m_regs[t_addr[3:2]] : 32'h0;
        if (t_legal && t_we) m_regs[t_addr[3:2]] <= t_wdata;
        m_age <= 2;
      end else if (m_age == 2) begin
        m_age <= 0;
      end else if (m0_req || m1_req) begin
        t_sel <= g; t_we <= g_we; t_addr <= g_addr; t_wdata <= g_wdata;
        t_legal <= legal(g_addr);
        m_last <= g;
        m_age  <= 1;
        if (legal(g_addr)) begin
          e_wr <= g_we; e_rd <= ~g_we; e_addr <= g_addr; e_wdata <= g_wdata;
        end
      end
    end
  end

  // ---------------- every-cycle compare ----------------
  logic [111:0] act_v, exp_v;
  assign act_v = {wr_en, rd_en, addr, wdata, m0_ack, m0_err, m0_rdata, m1_ack, m1_err, m1_rdata};
  assign exp_v = {e_wr, e_rd, e_addr, e_wdata, e_ack[0], e_err[0], e_rdata[0],
                  e_ack[1], e_err[1], e_rdata[1]};
  always @(negedge clk) begin
    n_checks <= n_checks + 1;
    if (act_v === exp_v) n_pass <= n_pass + 1;
    else $display("FAIL cycle_compare @%0d: got %h required %h", cyc, act_v, exp_v);
  end

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h required %h", name, act, exp);
  endtask

  task automatic do_txn(input int p, input logic we, input logic [9:0] a,
                        input logic [31:0] wd, output logic [31:0] rd,
                        output logic er, output int lat);
    int start;
    bit got;
    start = cyc; got = 1'b0; rd = '0; er = 1'b0; lat = -1;
    if (p == 0) begin m0_we = we; m0_addr = a; m0_wdata = wd; m0_req = 1'b1; end
    else        begin m1_we = we; m1_addr = a; m1_wdata = wd; m1_req = 1'b1; end
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (p == 0 && m0_ack)      begin got = 1'b1; rd = m0_rdata; er = m0_err; end
      else if (p == 1 && m1_ack) begin got = 1'b1; rd = m1_rdata; er = m1_err; end
      if (got) lat = cyc - start;
    end
    if (!got) begin
      n_checks++;
      $display("FAIL ack_timeout: port %0d got no ack in 20 cycles, required an ack", p);
    end
    @(posedge clk); #1;
    if (p == 0) m0_req = 1'b0; else m1_req = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk); rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  // ack order recorder
  bit rr_on = 1'b0;
  int rr_port[$];
  int rr_cyc[$];
  always @(negedge clk) begin
    if (rr_on && m0_ack) begin rr_port.push_back(0); rr_cyc.push_back(cyc); end
    if (rr_on && m1_ack) begin rr_port.push_back(1); rr_cyc.push_back(cyc); end
  end

  // ---------------- stimulus ----------------
  logic [31:0] rd, v;
  logic        er;
  int          lat, s0;
  logic [9:0]  reset_addrs [4];
  logic [31:0] reset_vals  [4];

  initial begin
    rst_n = 1'b0;
    m0_req = 0; m0_we = 0; m0_addr = '0; m0_wdata = '0;
    m1_req = 0; m1_we = 0; m1_addr = '0; m1_wdata = '0;
    reset_addrs[0] = 10'h8; reset_addrs[1] = 10'hC; reset_addrs[2] = 10'h0; reset_addrs[3] = 10'h4;
    reset_vals[0] = 32'hffff_ffff; reset_vals[1] = 32'hffff_ffff; reset_vals[2] = 32'h0; reset_vals[3] = 32'h0;
    repeat (3) @(negedge clk);
    chk("reset_wr_en", 32'(wr_en), 32'd0);
    chk("reset_m0_ack", 32'(m0_ack), 32'd0);
    chk("reset_m1_rdata", m1_rdata, 32'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // reset values, 2-cycle latency
    for (int i = 0; i < 4; i++) begin
      do_txn(0, 1'b0, reset_addrs[i], 32'h0, rd, er, lat);
      chk("reset_read_data", rd, reset_vals[i]);
      chk("reset_read_err", 32'(er), 32'd0);
      chk("reset_read_latency", 32'(lat), 32'd2);
    end

    // write / readback from both ports
    s0 = n_strobes;
    do_txn(0, 1'b1, 10'h8, 32'h1a2b_3c4d, rd, er, lat);
    chk("wr_single_strobe", 32'(n_strobes - s0), 32'd1);
    do_txn(0, 1'b0, 10'h8, 32'h0, rd, er, lat);
    chk("readback_m0", rd, 32'h1a2b_3c4d);
    do_txn(1, 1'b1, 10'h8, 32'haaaa_aaaa, rd, er, lat);
    do_txn(1, 1'b0, 10'h8, 32'h0, rd, er, lat);
    chk("readback_m1_a", rd, 32'haaaa_aaaa);
    do_txn(1, 1'b1, 10'h8, 32'h0, rd, er, lat);
    do_txn(1, 1'b0, 10'h8, 32'h0, rd, er, lat);
    chk("readback_m1_0", rd, 32'h0);

    // round-robin with both masters requesting continuously
    do_reset();
    rr_on = 1'b1;
    fork
      begin
        logic [31:0] r0; logic e0; int l0;
        do_txn(0, 1'b0, 10'h8, 32'h0, r0, e0, l0);
        do_txn(0, 1'b0, 10'h8, 32'h0, r0, e0, l0);
      end
      begin
        logic [31:0] r1; logic e1; int l1;
        do_txn(1, 1'b0, 10'h0, 32'h0, r1, e1, l1);
        do_txn(1, 1'b0, 10'h0, 32'h0, r1, e1, l1);
      end
    join
    rr_on = 1'b0;
    chk("rr_ack_count", 32'(rr_port.size()), 32'd4);
    if (rr_port.size() == 4) begin
      for (int i = 0; i < 4; i++) chk("rr_order", 32'(rr_port[i]), 32'(i % 2));
      for (int i = 1; i < 4; i++) chk("rr_spacing", 32'(rr_cyc[i] - rr_cyc[i-1]), 32'd3);
    end

    // illegal addresses never strobe
    s0 = n_strobes;
    do_txn(1, 1'b0, 10'h10, 32'h0, rd, er, lat);
    chk("illegal_rd_err", 32'(er), 32'd1);
    chk("illegal_rd_data", rd, 32'h0);
    do_txn(1, 1'b1, 10'h6, 32'hdead_beef, rd, er, lat);
    chk("illegal_wr_err", 32'(er), 32'd1);
    chk("illegal_no_strobe", 32'(n_strobes - s0), 32'd0);
    do_txn(1, 1'b0, 10'h8, 32'h0, rd, er, lat);
    chk("after_illegal_data", rd, 32'hffff_ffff);

    // reset during ACCESS of a write
    m0_we = 1'b1; m0_addr = 10'h8; m0_wdata = 32'h5555_5555; m0_req = 1'b1;
    @(negedge clk);           // IDLE cycle, request sampled at next edge
    @(negedge clk);           // ACCESS cycle
    chk("midrst_strobe_on", 32'(wr_en), 32'd1);
    #2 rst_n = 1'b0;
    #1 chk("midrst_strobe_drop", 32'(wr_en), 32'd0);
    m0_req = 1'b0;
    repeat (2) @(negedge clk);
    chk("midrst_no_ack", 32'(m0_ack), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    do_txn(0, 1'b0, 10'h8, 32'h0, rd, er, lat);
    chk("midrst_read", rd, 32'hffff_ffff);

    // back-to-back from one port
    s0 = n_strobes;
    do_txn(0, 1'b1, 10'h4, 32'h0bad_f00d, rd, er, lat);
    chk("b2b_first_latency", 32'(lat), 32'd2);
    do_txn(0, 1'b0, 10'h4, 32'h0, rd, er, lat);
    chk("b2b_second_latency", 32'(lat), 32'd2);
    chk("b2b_data", rd, 32'h0bad_f00d);
    chk("b2b_strobes", 32'(n_strobes - s0), 32'd2);

    // randomized traffic from both ports
    fork
      for (int p = 0; p < 2; p++) begin
        fork
          automatic int pp = p;
          begin
            logic [31:0] rr; logic ee; int ll;
            logic [9:0] a; logic w; int k;
            for (int n = 0; n < 15; n++) begin
              k = int'($urandom_range(0, 5));
              if (k < 4)       a = 10'(k * 4);
              else if (k == 4) a = 10'($urandom);
              else             a = 10'(($urandom_range(0, 3) * 4) + 1);
              w = 1'($urandom);
              do_txn(pp, w, a, $urandom, rr, ee, ll);
              chk("rand_err", 32'(ee), 32'(!legal(a)));
              repeat ($urandom_range(0, 2)) @(posedge clk);
              #1;
            end
          end
        join_none
      end
    join
    wait fork;

    repeat (4) @(posedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at 500us, required completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/regs_bus_arbiter.md
Name: regs_bus_arbiter

Overview:
Two-requester round-robin arbiter and sequencer for the 32-bit register block (DATA0/DATA0_SR/DATA1/DATA1_SR map). It accepts independent read/write requests from two masters, such as a CPU-side port and a debug/DMA port. It issues exactly one single-cycle wr_en/rd_en access to the register block at a time, and returns the captured read data with a one-cycle ack. Addresses outside the map, or not word-aligned, are rejected with an error response and no register access.

Parameters:
DW, 32, data width
AW, 10, address width
ADDR_DATA0, 10'h0, legal address 0
ADDR_DATA0_SR, 10'h4, legal address 1
ADDR_DATA1, 10'h8, legal address 2
ADDR_DATA1_SR, 10'hC, legal address 3

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  reset, asynchronous assert, active-low
m0_req  in  1  requester 0 request, held until m0_ack is sampled
m0_we  in  1  1 = write, 0 = read
m0_addr  in  AW  byte address
m0_wdata  in  DW  write data
m0_ack  out  1  one-cycle completion pulse
m0_err  out  1  valid with m0_ack; 1 = illegal address
m0_rdata  out  DW  read data, valid with m0_ack
m1_req, m1_we, m1_addr, m1_wdata, m1_ack, m1_err, m1_rdata  (same as m0, requester 1)
wr_en  out  1  register block write strobe
rd_en  out  1  register block read strobe
addr  out  AW  register block address
wdata  out  DW  register block write data
rdata  in  DW  register block read data, combinational from addr/rd_en

Behaviour:
- Reset (async, rst_n=0): state=IDLE. wr_en, rd_en, addr, wdata, all mX_ack, mX_err and mX_rdata = 0. last_grant=1, so requester 0 wins the first tie.
- FSM states: IDLE, ACCESS, RESP. All outputs are registered.
- IDLE:
  - If no req, stay in IDLE.
  - If exactly one req, grant it.
  - If both req, grant the requester != last_grant.
  - On grant: latch sel, we, addr and wdata; update last_grant=sel.
  - Legal address: drive addr/wdata and set wr_en=we, rd_en=~we for the next cycle; go to ACCESS.
  - Illegal address (not one of the 4 parameters, including unaligned): no strobe; set pending err; go to ACCESS with strobes 0.
- ACCESS (exactly 1 cycle):
  - Strobes are high for this cycle only; the register block writes at the end-of-cycle edge.
  - At the same edge: clear wr_en, rd_en, addr and wdata to 0.
  - For a legal read, capture rdata into m{sel}_rdata. For a write or an error, m{sel}_rdata=0.
  - Assert m{sel}_ack=1, and m{sel}_err=1 if the address was illegal. Go to RESP.
- RESP (1 cycle): ack/err/rdata visible. At the next edge clear ack and err (rdata holds its value until the next response to the same port). Go to IDLE.
- Latency: request present in IDLE at cycle N → strobe in cycle N+1 → ack in cycle N+2. Maximum throughput is 1 transaction per 3 cycles.
- Requester rule: keep req and fields stable until the edge where ack=1 is sampled. The requester may drop req, or present a new request with updated fields, at that same edge. The FSM samples req only in IDLE, so there is no double-service.
- Non-granted requester: waits; its req is ignored until IDLE. Starvation bound is one transaction.
- The ack of the non-selected port stays 0 at all times. At most one of m0_ack/m1_ack is high in any cycle.
- wr_en and rd_en are never high together, and never high outside ACCESS.
- Reset mid-operation: the strobe drops immediately (asynchronously). The in-flight transaction is discarded with no ack; the requester must reissue after reset.
- Read data is taken from rdata unmodified. DATA1/DATA1_SR reset to ffff_ffff; DATA0/DATA0_SR reset to 0.

Test Plan:
1. Reset reads: after rst_n rises, m0 reads 0x8, 0xC, 0x0 and 0x4 → m0_rdata = ffff_ffff, ffff_ffff, 0, 0, with err=0 and each ack exactly 2 cycles after req is sampled.
2. Write/readback: m0 writes 1a2b_3c4d to 0x8, then reads 0x8 → wr_en is a single-cycle pulse with addr=0x8, and the read returns 1a2b_3c4d. Repeat with aaaa_aaaa and 0 from m1.
3. Round-robin: m0 and m1 both hold req continuously for 4 transactions (m0 reads 0x8, m1 reads 0x0) → acks arrive in the order m0, m1, m0, m1, 3 cycles apart, and never in the same cycle.
4. Illegal address: m1 reads 0x10, then writes 0x6 → m1_ack with m1_err=1 and m1_rdata=0; wr_en and rd_en stay 0 throughout; a subsequent read of 0x8 returns an unchanged value.
5. Reset mid-access: assert rst_n=0 during the ACCESS cycle of an m0 write of 5555_5555 to 0x8 → wr_en falls immediately, no m0_ack occurs, and a post-reset read of 0x8 returns ffff_ffff.
6. Back-to-back from one port: m0 presents a new request at the ack edge → the next strobe occurs 1 cycle after RESP, with no missed or duplicated transaction.
